seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter: loads a PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clock, for a programmed number of frames. Optional idle gap between frames. Drives the serial bit input of the team's Mealy sequence detectors as on-chip stimulus and loopback source. Start/busy/done handshake toward the controlling logic.

Parameters:
PAT_W, 4, pattern length in bits (2..16).
GAP, 0, idle cycles inserted between consecutive frames (0..15).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request to begin transmission; sampled only in IDLE.
pat_in  input  PAT_W  pattern; captured on the accepted start edge.
rep  input  8  frame count; captured with pat_in; 0 is treated as 1.
abort  input  1  synchronous cancel of an active transmission.
x  output  1  serial data bit, MSB of pattern first.
x_valid  output  1  high while x carries a pattern bit.
frame_end  output  1  high during the last bit of each frame.
busy  output  1  high from the first bit through the last bit/gap cycle.
done  output  1  one-cycle pulse after the final bit of the final frame.

Behaviour:
- All outputs are registered. Reset (rst=0) asynchronously forces: state IDLE, x=0, x_valid=0, frame_end=0, busy=0, done=0, all counters 0. Reset mid-transmission abandons it with no done pulse.
- States: IDLE, SEND, GAP.
- IDLE: x=0, x_valid=0, busy=0. On an edge with start=1 and abort=0:
  - latch pat_in into pat_reg and shreg.
  - load frames_left = (rep==0) ? 1 : rep.
  - load bitcnt = PAT_W-1.
  - go to SEND.
  - After that edge: x=pat_in[PAT_W-1], x_valid=1, busy=1. First bit latency is 1 cycle.
- SEND: each edge shifts shreg left and decrements bitcnt. x_valid=1 throughout. frame_end=1 exactly while bitcnt==0 (last bit on x). At the edge ending the last bit:
  - frames_left>1 and GAP>0: decrement frames_left, go to GAP with gapcnt=GAP-1. x=0, x_valid=0, busy=1.
  - frames_left>1 and GAP=0: decrement frames_left, reload shreg from pat_reg, bitcnt=PAT_W-1, stay in SEND. Bits stay back-to-back with no bubble.
  - frames_left==1: go to IDLE. done=1 and busy=0 for that one cycle. x=0, x_valid=0.
- GAP: x=0, x_valid=0, busy=1. Decrement gapcnt each edge. At the edge where gapcnt==0: reload shreg from pat_reg, bitcnt=PAT_W-1, go to SEND.
- start while busy is ignored, not queued. pat_in and rep changes after capture have no effect.
- start asserted in the done cycle is accepted, since the state is IDLE. The first bit of the new run appears the next cycle.
- abort=1 in SEND or GAP: next edge goes to IDLE. All outputs drop to 0 and no done pulse. abort has priority over start in IDLE.
- frames_left is 8 bits and never wraps: rep=255 sends exactly 255 frames. bitcnt width is $clog2(PAT_W); gapcnt is 4 bits.
- Total busy cycles per run = F*PAT_W + (F-1)*GAP, with F = max(rep,1).

Test Plan:
- Reset, then pat_in=4'b0110, rep=1, pulse start for 1 cycle. Required: x=0,1,1,0 on 4 consecutive cycles starting 1 cycle after start; x_valid=1 for exactly those 4; frame_end on the 4th; done=1 on the 5th; busy=1 for cycles 1-4.
- rep=3, GAP=0, pattern 0110. Required: 12 back-to-back valid bits 011001100110; frame_end on bits 4, 8, 12; a single done pulse after bit 12.
- GAP=2, rep=2, pattern 1011. Required: 1,0,1,1, then 2 cycles with x_valid=0 and busy=1, then 1,0,1,1, then done. rep=0 behaves exactly like rep=1.
- During a run, assert start and change pat_in to 4'b1111. Required: transmission unaffected, no restart. Start in the done cycle: the new run's first bit appears the next cycle.
- abort during bit 2 of frame 1 (rep=3). Required: the next cycle has x_valid=0, busy=0, and done never pulses. Separately, drive rst=0 asynchronously mid-frame: outputs go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - start/pattern request and serial output bundle for seq_pattern_tx
//
// Purpose: groups the controller-facing request signals and the serial
// output/status signals of the pattern transmitter.
// Signals:
//   start     request to begin a run (controller -> tx)
//   pat_in    PAT_W-bit pattern, captured on accepted start
//   rep       frame count, 0 treated as 1
//   abort     synchronous cancel of an active run
//   x         serial bit, pattern MSB first (tx -> consumer)
//   x_valid   x carries a pattern bit
//   frame_end last bit of a frame is on x
//   busy      run in progress (bits and gaps)
//   done      one-cycle pulse after the final bit
// Modports: master = controller side, slave = transmitter side.

interface seq_pattern_tx_if #(
  parameter int PAT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pat_in;
  logic [7:0]       rep;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             frame_end;
  logic             busy;
  logic             done;

  modport master (
    output start, pat_in, rep, abort,
    input  x, x_valid, frame_end, busy, done
  );

  modport slave (
    input  start, pat_in, rep, abort,
    output x, x_valid, frame_end, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB first, repeated frames with optional gap
//
// Purpose: on an accepted start, captures a PAT_W-bit pattern and a frame
// count, then shifts the pattern out one bit per clock for the requested
// number of frames, optionally separated by GAP idle cycles.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  seq_pattern_tx_if.slave (start/pat_in/rep/abort in; x/x_valid/
//        frame_end/busy/done out, all registered)

module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int GAP   = 0
) (
  input  logic            clk,
  input  logic            rst,
  seq_pattern_tx_if.slave bus
);

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);
  // Only meaningful when GAP > 0; guarded at the use site.
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [7:0]       frames_q, frames_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [3:0]       gapcnt_q, gapcnt_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             fe_q, fe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      sh_q     <= '0;
      frames_q <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      x_q      <= 1'b0;
      xv_q     <= 1'b0;
      fe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      sh_q     <= sh_d;
      frames_q <= frames_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      x_q      <= x_d;
      xv_q     <= xv_d;
      fe_q     <= fe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    sh_d     = sh_q;
    frames_d = frames_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort wins over start so a stale abort cannot launch a run
        if (bus.start && !bus.abort) begin
          pat_d    = bus.pat_in;
          sh_d     = bus.pat_in;
          frames_d = (bus.rep == 8'd0) ? 8'd1 : bus.rep;
          bitcnt_d = LAST_BIT;
          state_d  = S_SEND;
        end
      end

      S_SEND: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bitcnt_q == '0) begin
          if (frames_q > 8'd1) begin
            frames_d = frames_q - 8'd1;
            if (GAP > 0) begin
              gapcnt_d = GAP_LOAD;
              state_d  = S_GAP;
            end else begin
              // reload in place so the next frame follows without a bubble
              sh_d     = pat_q;
              bitcnt_d = LAST_BIT;
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          sh_d     = sh_q << 1;
          bitcnt_d = bitcnt_q - BW'(1);
        end
      end

      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (gapcnt_q == 4'd0) begin
          sh_d     = pat_q;
          bitcnt_d = LAST_BIT;
          state_d  = S_SEND;
        end else begin
          gapcnt_d = gapcnt_q - 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    xv_d   = (state_d == S_SEND);
    x_d    = xv_d & sh_d[PAT_W-1];
    fe_d   = xv_d & (bitcnt_d == '0);
    busy_d = (state_d != S_IDLE);
  end

  assign bus.x         = x_q;
  assign bus.x_valid   = xv_q;
  assign bus.frame_end = fe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx

module tb_seq_pattern_tx;

  logic clk;
  logic rst_n;

  int tests_run;
  int tests_failed;

  // u0: GAP=0, u2: GAP=2, both PAT_W=4
  seq_pattern_tx_if #(.PAT_W(4)) if0 ();
  seq_pattern_tx_if #(.PAT_W(4)) if2 ();

  seq_pattern_tx #(.PAT_W(4), .GAP(0)) u0 (
    .clk (clk),
    .rst (rst_n),
    .bus (if0.slave)
  );

  seq_pattern_tx #(.PAT_W(4), .GAP(2)) u2 (
    .clk (clk),
    .rst (rst_n),
    .bus (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // captured outputs, earliest cycle ends up at the highest bit
  logic [31:0] c_x, c_xv, c_fe, c_busy, c_done;

  task automatic capture(input int sel, input int n);
    c_x = '0; c_xv = '0; c_fe = '0; c_busy = '0; c_done = '0;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin
        c_x    = {c_x[30:0],    if0.x};
        c_xv   = {c_xv[30:0],   if0.x_valid};
        c_fe   = {c_fe[30:0],   if0.frame_end};
        c_busy = {c_busy[30:0], if0.busy};
        c_done = {c_done[30:0], if0.done};
      end else begin
        c_x    = {c_x[30:0],    if2.x};
        c_xv   = {c_xv[30:0],   if2.x_valid};
        c_fe   = {c_fe[30:0],   if2.frame_end};
        c_busy = {c_busy[30:0], if2.busy};
        c_done = {c_done[30:0], if2.done};
      end
      @(negedge clk);
    end
  endtask

  // called at a negedge; returns at the negedge where bit 1 is visible
  task automatic start_pulse(input int sel, input logic [3:0] pat, input logic [7:0] rep);
    if (sel == 0) begin
      if0.pat_in = pat; if0.rep = rep; if0.start = 1'b1;
    end else begin
      if2.pat_in = pat; if2.rep = rep; if2.start = 1'b1;
    end
    @(negedge clk);
    if0.start = 1'b0;
    if2.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.start = 1'b0; if0.pat_in = '0; if0.rep = '0; if0.abort = 1'b0;
    if2.start = 1'b0; if2.pat_in = '0; if2.rep = '0; if2.abort = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({if0.x, if0.x_valid, if0.frame_end, if0.busy, if0.done} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_u0: got %b expected 00000",
               {if0.x, if0.x_valid, if0.frame_end, if0.busy, if0.done});
    end
    tests_run++;
    if ({if2.x, if2.x_valid, if2.frame_end, if2.busy, if2.done} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_u2: got %b expected 00000",
               {if2.x, if2.x_valid, if2.frame_end, if2.busy, if2.done});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    start_pulse(0, 4'b0110, 8'd1);
    capture(0, 6);
    tests_run++;
    if (c_x[5:0] !== 6'b011000) begin
      tests_failed++; $display("FAIL single_x: got %b expected 011000", c_x[5:0]);
    end
    tests_run++;
    if (c_xv[5:0] !== 6'b111100) begin
      tests_failed++; $display("FAIL single_xv: got %b expected 111100", c_xv[5:0]);
    end
    tests_run++;
    if (c_fe[5:0] !== 6'b000100) begin
      tests_failed++; $display("FAIL single_fe: got %b expected 000100", c_fe[5:0]);
    end
    tests_run++;
    if (c_busy[5:0] !== 6'b111100) begin
      tests_failed++; $display("FAIL single_busy: got %b expected 111100", c_busy[5:0]);
    end
    tests_run++;
    if (c_done[5:0] !== 6'b000010) begin
      tests_failed++; $display("FAIL single_done: got %b expected 000010", c_done[5:0]);
    end
  endtask

  task automatic test_back_to_back();
    start_pulse(0, 4'b0110, 8'd3);
    capture(0, 14);
    tests_run++;
    if (c_x[13:0] !== 14'b01100110011000) begin
      tests_failed++; $display("FAIL b2b_x: got %b expected 01100110011000", c_x[13:0]);
    end
    tests_run++;
    if (c_xv[13:0] !== 14'b11111111111100) begin
      tests_failed++; $display("FAIL b2b_xv: got %b expected 11111111111100", c_xv[13:0]);
    end
    tests_run++;
    if (c_fe[13:0] !== 14'b00010001000100) begin
      tests_failed++; $display("FAIL b2b_fe: got %b expected 00010001000100", c_fe[13:0]);
    end
    tests_run++;
    if (c_done[13:0] !== 14'b00000000000010) begin
      tests_failed++; $display("FAIL b2b_done: got %b expected 00000000000010", c_done[13:0]);
    end
  endtask

  task automatic test_gap();
    start_pulse(2, 4'b1011, 8'd2);
    capture(2, 12);
    tests_run++;
    if (c_x[11:0] !== 12'b101100101100) begin
      tests_failed++; $display("FAIL gap_x: got %b expected 101100101100", c_x[11:0]);
    end
    tests_run++;
    if (c_xv[11:0] !== 12'b111100111100) begin
      tests_failed++; $display("FAIL gap_xv: got %b expected 111100111100", c_xv[11:0]);
    end
    tests_run++;
    if (c_busy[11:0] !== 12'b111111111100) begin
      tests_failed++; $display("FAIL gap_busy: got %b expected 111111111100", c_busy[11:0]);
    end
    tests_run++;
    if (c_fe[11:0] !== 12'b000100000100) begin
      tests_failed++; $display("FAIL gap_fe: got %b expected 000100000100", c_fe[11:0]);
    end
    tests_run++;
    if (c_done[11:0] !== 12'b000000000010) begin
      tests_failed++; $display("FAIL gap_done: got %b expected 000000000010", c_done[11:0]);
    end
  endtask

  task automatic test_rep_zero();
    start_pulse(2, 4'b1011, 8'd0);
    capture(2, 6);
    tests_run++;
    if (c_x[5:0] !== 6'b101100) begin
      tests_failed++; $display("FAIL rep0_x: got %b expected 101100", c_x[5:0]);
    end
    tests_run++;
    if (c_busy[5:0] !== 6'b111100) begin
      tests_failed++; $display("FAIL rep0_busy: got %b expected 111100", c_busy[5:0]);
    end
    tests_run++;
    if (c_done[5:0] !== 6'b000010) begin
      tests_failed++; $display("FAIL rep0_done: got %b expected 000010", c_done[5:0]);
    end
  endtask

  task automatic test_start_ignored();
    start_pulse(0, 4'b0110, 8'd2);
    // hold start with a different pattern through the run and the done cycle
    if0.start = 1'b1; if0.pat_in = 4'b1111; if0.rep = 8'd5;
    capture(0, 10);
    if0.start = 1'b0;
    tests_run++;
    if (c_x[9:0] !== 10'b0110011001) begin
      tests_failed++; $display("FAIL ignore_x: got %b expected 0110011001", c_x[9:0]);
    end
    tests_run++;
    if (c_xv[9:0] !== 10'b1111111101) begin
      tests_failed++; $display("FAIL ignore_xv: got %b expected 1111111101", c_xv[9:0]);
    end
    tests_run++;
    if (c_done[9:0] !== 10'b0000000010) begin
      tests_failed++; $display("FAIL ignore_done: got %b expected 0000000010", c_done[9:0]);
    end
    // kill the restarted run
    if0.abort = 1'b1;
    @(negedge clk);
    if0.abort = 1'b0;
    tests_run++;
    if ({if0.x_valid, if0.busy, if0.done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL restart_abort: got %b expected 000", {if0.x_valid, if0.busy, if0.done});
    end
  endtask

  task automatic test_abort();
    start_pulse(0, 4'b0110, 8'd3);
    @(negedge clk);               // bit 2 of frame 1 on x
    tests_run++;
    if ({if0.x, if0.x_valid} !== 2'b11) begin
      tests_failed++; $display("FAIL abort_pre: got %b expected 11", {if0.x, if0.x_valid});
    end
    if0.abort = 1'b1;
    @(negedge clk);
    if0.abort = 1'b0;
    tests_run++;
    if ({if0.x, if0.x_valid, if0.frame_end, if0.busy, if0.done} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL abort_send: got %b expected 00000",
               {if0.x, if0.x_valid, if0.frame_end, if0.busy, if0.done});
    end
    capture(0, 14);
    tests_run++;
    if ((c_done[13:0] | c_xv[13:0]) !== 14'b0) begin
      tests_failed++;
      $display("FAIL abort_quiet: done %b xv %b expected all 0", c_done[13:0], c_xv[13:0]);
    end
    // abort while in the gap
    start_pulse(2, 4'b1011, 8'd2);
    repeat (4) @(negedge clk);    // now in first gap cycle
    tests_run++;
    if ({if2.x_valid, if2.busy} !== 2'b01) begin
      tests_failed++; $display("FAIL abort_gap_pre: got %b expected 01", {if2.x_valid, if2.busy});
    end
    if2.abort = 1'b1;
    @(negedge clk);
    if2.abort = 1'b0;
    capture(2, 8);
    tests_run++;
    if ((c_done[7:0] | c_busy[7:0] | c_xv[7:0]) !== 8'b0) begin
      tests_failed++;
      $display("FAIL abort_gap: done %b busy %b xv %b expected all 0",
               c_done[7:0], c_busy[7:0], c_xv[7:0]);
    end
    // abort beats start in IDLE
    if0.start = 1'b1; if0.abort = 1'b1; if0.pat_in = 4'b1111; if0.rep = 8'd1;
    @(negedge clk);
    if0.start = 1'b0; if0.abort = 1'b0;
    tests_run++;
    if ({if0.x_valid, if0.busy} !== 2'b00) begin
      tests_failed++; $display("FAIL abort_prio: got %b expected 00", {if0.x_valid, if0.busy});
    end
  endtask

  task automatic test_async_reset();
    start_pulse(0, 4'b0110, 8'd2);
    @(negedge clk);               // bit 2 (=1) on x
    tests_run++;
    if ({if0.x, if0.busy} !== 2'b11) begin
      tests_failed++; $display("FAIL areset_pre: got %b expected 11", {if0.x, if0.busy});
    end
    #2 rst_n = 1'b0;              // well before the next rising edge
    #1;
    tests_run++;
    if ({if0.x, if0.x_valid, if0.frame_end, if0.busy, if0.done} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL areset_now: got %b expected 00000",
               {if0.x, if0.x_valid, if0.frame_end, if0.busy, if0.done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    capture(0, 10);
    tests_run++;
    if ((c_done[9:0] | c_xv[9:0]) !== 10'b0) begin
      tests_failed++;
      $display("FAIL areset_quiet: done %b xv %b expected all 0", c_done[9:0], c_xv[9:0]);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap();
    test_rep_zero();
    test_start_ignored();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
